// File: rtl/mem_store_unit_if.sv
// Store-path bus between the memory stage and the store unit: request, RAM write port,
// UART transmitter handshake and status outputs.
interface mem_store_unit_if;
  logic        st_valid;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        pc_bios;
  logic        stall;
  logic [3:0]  dmem_we;
  logic [3:0]  imem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_din;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic        cnt_rst;
  logic [7:0]  misalign_cnt;

  modport master (
    output st_valid, st_funct3, st_addr, st_data, pc_bios, uart_tx_ready,
    input  stall, dmem_we, imem_we, mem_addr, mem_din, uart_tx_data, uart_tx_valid,
           cnt_rst, misalign_cnt
  );

  modport slave (
    input  st_valid, st_funct3, st_addr, st_data, pc_bios, uart_tx_ready,
    output stall, dmem_we, imem_we, mem_addr, mem_din, uart_tx_data, uart_tx_valid,
           cnt_rst, misalign_cnt
  );
endinterface

// File: rtl/mem_store_unit.sv
// Store unit: decodes store region and width into RAM byte enables, buffers one UART byte,
// pulses counter reset and counts rejected misaligned stores.
module mem_store_unit (
  input logic              clk,
  input logic              rst,
  mem_store_unit_if.slave  bus
);
  localparam logic [2:0]  F3Sb     = 3'b000;
  localparam logic [2:0]  F3Sh     = 3'b001;
  localparam logic [2:0]  F3Sw     = 3'b010;
  localparam logic [31:0] UartAddr = 32'h8000_0008;
  localparam logic [31:0] CntAddr  = 32'h8000_0018;

  logic       tx_full_q, tx_full_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       cnt_rst_q, cnt_rst_d;
  logic [7:0] misalign_cnt_q, misalign_cnt_d;

  logic       is_uart, is_cnt, accept, legal, misaligned, write_ok;
  logic       region_dmem, region_imem;
  logic [3:0] lanes;

  always_comb begin
    is_uart     = (bus.st_addr == UartAddr);
    is_cnt      = (bus.st_addr == CntAddr);
    legal       = 1'b0;
    misaligned  = 1'b0;
    lanes       = 4'b0000;
    bus.mem_din = bus.st_data;
    case (bus.st_funct3)
      F3Sb: begin
        legal       = 1'b1;
        lanes       = 4'b0001 << bus.st_addr[1:0];
        bus.mem_din = {4{bus.st_data[7:0]}};
      end
      F3Sh: begin
        legal       = 1'b1;
        misaligned  = bus.st_addr[0];
        lanes       = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        bus.mem_din = {2{bus.st_data[15:0]}};
      end
      F3Sw: begin
        legal      = 1'b1;
        misaligned = (bus.st_addr[1:0] != 2'b00);
        lanes      = 4'b1111;
      end
      default: ;
    endcase

    region_dmem = 1'b0;
    region_imem = 1'b0;
    case (bus.st_addr[31:28])
      4'b0001: region_dmem = 1'b1;
      4'b0010: region_imem = 1'b1;
      4'b0011: begin
        region_dmem = 1'b1;
        region_imem = 1'b1;
      end
      default: ;
    endcase

    // Stall depends only on the address so it never waits on alignment decode.
    bus.stall = ~rst & bus.st_valid & is_uart & tx_full_q & ~bus.uart_tx_ready;
    accept    = ~rst & bus.st_valid & ~bus.stall;
    write_ok  = accept & legal & ~misaligned;

    bus.dmem_we       = (write_ok & region_dmem) ? lanes : 4'b0000;
    bus.imem_we       = (write_ok & region_imem & bus.pc_bios) ? lanes : 4'b0000;
    bus.mem_addr      = bus.st_addr[15:2];
    bus.uart_tx_valid = tx_full_q & ~rst;
    bus.uart_tx_data  = tx_byte_q;
    bus.cnt_rst       = cnt_rst_q;
    bus.misalign_cnt  = misalign_cnt_q;

    // A load on a drain edge overwrites the draining byte and keeps the buffer full.
    tx_full_d = tx_full_q;
    tx_byte_d = tx_byte_q;
    if (write_ok && is_uart) begin
      tx_full_d = 1'b1;
      tx_byte_d = bus.st_data[7:0];
    end else if (tx_full_q && bus.uart_tx_ready) begin
      tx_full_d = 1'b0;
    end

    cnt_rst_d      = write_ok & is_cnt;
    misalign_cnt_d = misalign_cnt_q;
    if (accept && legal && misaligned && (misalign_cnt_q != 8'hFF)) begin
      misalign_cnt_d = misalign_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_full_q      <= 1'b0;
      tx_byte_q      <= 8'h00;
      cnt_rst_q      <= 1'b0;
      misalign_cnt_q <= 8'h00;
    end else begin
      tx_full_q      <= tx_full_d;
      tx_byte_q      <= tx_byte_d;
      cnt_rst_q      <= cnt_rst_d;
      misalign_cnt_q <= misalign_cnt_d;
    end
  end
endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit: a table of combinational store decodes plus
// hand-written UART, counter-reset, misalignment and reset sequences.
module tb_mem_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_store_unit_if bus ();

  mem_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        bios;
    logic [3:0]  dwe;
    logic [3:0]  iwe;
    logic [13:0] maddr;
    logic [31:0] din;
    logic        chk_din;
  } vec_t;

  vec_t vecs [10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic b);
    bus.st_valid  = v;
    bus.st_funct3 = f3;
    bus.st_addr   = a;
    bus.st_data   = d;
    bus.pc_bios   = b;
  endtask

  initial begin
    vecs[0] = '{3'b000, 32'h1000_0003, 32'h0000_00AB, 1'b0, 4'b1000, 4'b0000, 14'h0000,
                32'hABAB_ABAB, 1'b1};
    vecs[1] = '{3'b010, 32'h3000_0010, 32'h1234_5678, 1'b1, 4'b1111, 4'b1111, 14'h0004,
                32'h1234_5678, 1'b1};
    vecs[2] = '{3'b010, 32'h3000_0010, 32'h1234_5678, 1'b0, 4'b1111, 4'b0000, 14'h0004,
                32'h1234_5678, 1'b1};
    vecs[3] = '{3'b001, 32'h2000_0006, 32'h0000_BEEF, 1'b1, 4'b0000, 4'b1100, 14'h0001,
                32'hBEEF_BEEF, 1'b1};
    vecs[4] = '{3'b000, 32'h2000_0001, 32'h0000_0033, 1'b0, 4'b0000, 4'b0000, 14'h0000,
                32'h3333_3333, 1'b1};
    vecs[5] = '{3'b001, 32'h1000_0000, 32'hCAFE_1234, 1'b0, 4'b0011, 4'b0000, 14'h0000,
                32'h1234_1234, 1'b1};
    vecs[6] = '{3'b011, 32'h1000_0000, 32'hDEAD_BEEF, 1'b1, 4'b0000, 4'b0000, 14'h0000,
                32'h0, 1'b0};
    vecs[7] = '{3'b010, 32'h4000_FFFC, 32'h0BAD_F00D, 1'b1, 4'b0000, 4'b0000, 14'h3FFF,
                32'h0BAD_F00D, 1'b1};
    vecs[8] = '{3'b000, 32'h1000_ABCD, 32'h0000_007F, 1'b0, 4'b0010, 4'b0000, 14'h2AF3,
                32'h7F7F_7F7F, 1'b1};
    vecs[9] = '{3'b010, 32'h8000_0004, 32'h0000_0099, 1'b0, 4'b0000, 4'b0000, 14'h0001,
                32'h0000_0099, 1'b1};

    bus.uart_tx_ready = 1'b1;
    drive(1'b1, 3'b010, 32'h3000_0010, 32'hFFFF_FFFF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dmem_we", {28'b0, bus.dmem_we}, 32'h0);
    chk("rst_imem_we", {28'b0, bus.imem_we}, 32'h0);
    chk("rst_stall", {31'b0, bus.stall}, 32'h0);
    chk("rst_tx_valid", {31'b0, bus.uart_tx_valid}, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    #1;
    chk("reset_misalign_cnt", {24'b0, bus.misalign_cnt}, 32'h0);
    chk("reset_cnt_rst", {31'b0, bus.cnt_rst}, 32'h0);
    chk("reset_tx_data", {24'b0, bus.uart_tx_data}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].f3, vecs[i].addr, vecs[i].data, vecs[i].bios);
      #1;
      chk($sformatf("v%0d_dmem_we", i), {28'b0, bus.dmem_we}, {28'b0, vecs[i].dwe});
      chk($sformatf("v%0d_imem_we", i), {28'b0, bus.imem_we}, {28'b0, vecs[i].iwe});
      chk($sformatf("v%0d_mem_addr", i), {18'b0, bus.mem_addr}, {18'b0, vecs[i].maddr});
      if (vecs[i].chk_din) chk($sformatf("v%0d_mem_din", i), bus.mem_din, vecs[i].din);
      chk($sformatf("v%0d_stall", i), {31'b0, bus.stall}, 32'h0);
    end

    // Misaligned stores: rejected, counted, saturating.
    @(negedge clk);
    drive(1'b1, 3'b001, 32'h1000_0001, 32'h1111_1111, 1'b1);
    #1;
    chk("mis_sh_dmem_we", {28'b0, bus.dmem_we}, 32'h0);
    @(negedge clk);
    chk("mis_cnt_1", {24'b0, bus.misalign_cnt}, 32'h1);
    drive(1'b1, 3'b010, 32'h1000_0002, 32'h2222_2222, 1'b1);
    #1;
    chk("mis_sw_dmem_we", {28'b0, bus.dmem_we}, 32'h0);
    @(negedge clk);
    chk("mis_cnt_2", {24'b0, bus.misalign_cnt}, 32'h2);
    drive(1'b1, 3'b001, 32'h1000_0001, 32'h0, 1'b0);
    repeat (298) @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    chk("mis_cnt_sat", {24'b0, bus.misalign_cnt}, 32'hFF);

    // Counter reset pulse.
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h8000_0018, 32'h0, 1'b0);
    #1;
    chk("cnt_rst_before", {31'b0, bus.cnt_rst}, 32'h0);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    chk("cnt_rst_pulse", {31'b0, bus.cnt_rst}, 32'h1);
    @(negedge clk);
    chk("cnt_rst_after", {31'b0, bus.cnt_rst}, 32'h0);

    // UART handshake with back-pressure and same-edge drain/load.
    bus.uart_tx_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h8000_0008, 32'h0000_0041, 1'b0);
    #1;
    chk("uart_first_stall", {31'b0, bus.stall}, 32'h0);
    @(negedge clk);
    chk("uart_41_valid", {31'b0, bus.uart_tx_valid}, 32'h1);
    chk("uart_41_data", {24'b0, bus.uart_tx_data}, 32'h41);
    drive(1'b1, 3'b000, 32'h8000_0008, 32'h0000_0042, 1'b0);
    #1;
    chk("uart_42_stall", {31'b0, bus.stall}, 32'h1);
    @(negedge clk);
    chk("uart_41_held", {24'b0, bus.uart_tx_data}, 32'h41);
    chk("uart_42_stall2", {31'b0, bus.stall}, 32'h1);
    bus.uart_tx_ready = 1'b1;
    #1;
    chk("uart_42_nostall", {31'b0, bus.stall}, 32'h0);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    chk("uart_42_valid", {31'b0, bus.uart_tx_valid}, 32'h1);
    chk("uart_42_data", {24'b0, bus.uart_tx_data}, 32'h42);
    @(negedge clk);
    chk("uart_drained", {31'b0, bus.uart_tx_valid}, 32'h0);

    // Reset with a byte stuck in the buffer.
    bus.uart_tx_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h8000_0008, 32'h0000_0055, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", {31'b0, bus.uart_tx_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("in_rst_stall", {31'b0, bus.stall}, 32'h0);
    chk("in_rst_valid", {31'b0, bus.uart_tx_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    #1;
    chk("post_rst_valid", {31'b0, bus.uart_tx_valid}, 32'h0);
    chk("post_rst_stall", {31'b0, bus.stall}, 32'h0);
    chk("post_rst_cnt", {24'b0, bus.misalign_cnt}, 32'h0);
    drive(1'b1, 3'b000, 32'h1000_0000, 32'h0000_0012, 1'b0);
    #1;
    chk("first_store_we", {28'b0, bus.dmem_we}, 32'h1);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    chk("buffer_discarded", {31'b0, bus.uart_tx_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
